lcd_cmd_arbiter: RTL and testbench
==================================

Name: lcd_cmd_arbiter

Overview:
- Shares the single 4-bit LCD nibble command channel between up to NUM_REQ requesters, e.g. the power-up init sequencer (req 0), lcd_send_text (req 1), and an optional custom-glyph loader.
- A requester holds the channel for a whole transaction (many nibbles) via a locked grant, so text and init nibbles never interleave.
- Sits between the requesters and the nibble writer. It forwards one command at a time, routes commandDone back to the owner, and aborts a hung owner on watchdog timeout.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TIMEOUT_W, 20, width of the watchdog counter; timeout fires after 2^TIMEOUT_W-1 cycles without commandDone

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
req  in  NUM_REQ  level request per requester; held high for the whole transaction
reqSend  in  NUM_REQ  one-cycle pulse: the requester issues a nibble
reqCmd  in  4*NUM_REQ  nibble per requester; requester i uses bits [4i+3:4i]
reqRs  in  NUM_REQ  RS bit per requester
reqReadBusy  in  NUM_REQ  read_busy flag per requester
grant  out  NUM_REQ  one-hot ownership, registered
reqDone  out  NUM_REQ  commandDone routed to the owner only
commandToSend  out  4  nibble to the writer, registered
commandToSendRs  out  1  RS to the writer, registered
read_busy  out  1  read_busy to the writer, registered
sendCommand  out  1  one-cycle send pulse to the writer, registered
commandDone  in  1  writer completion pulse
timeoutErr  out  1  sticky flag: watchdog abort occurred
protocolErr  out  1  sticky flag: illegal send observed

Behaviour:
Reset:
- Synchronous. All outputs go to 0 and the state goes to IDLE.
- The round-robin pointer is set to 0, so requester 0 has highest priority first.

States:
- IDLE:
  - If any req is high, pick the first high req starting at the pointer (round-robin).
  - Register the one-hot grant and go to OWNED. Grant is visible 1 cycle after req rises.
- OWNED:
  - If reqSend of the owner is high, latch reqCmd/reqRs/reqReadBusy of the owner onto the outputs, pulse sendCommand for exactly 1 cycle (1-cycle latency), clear the watchdog and go to INFLIGHT.
  - Else, if req of the owner is low: clear grant, move the pointer to owner+1 (mod NUM_REQ), go to IDLE.
  - Same-cycle reqSend and a dropped req: the send wins, and release is deferred.
- INFLIGHT:
  - The watchdog increments every cycle.
  - On commandDone: pulse reqDone of the owner in the same cycle (combinational route), then go to OWNED. If req of the owner is already low, release directly to IDLE instead.
  - If the watchdog reaches all-ones: set timeoutErr, clear grant, advance the pointer, go to IDLE. No reqDone is issued.

Output holding:
- commandToSend, commandToSendRs and read_busy hold their last values between sends, because the writer samples them over multiple cycles.

Ignored inputs:
- reqSend from a non-owner is ignored.
- reqSend from the owner while in INFLIGHT is ignored.
- Both of these set protocolErr.

reqDone gating:
- reqDone is 0 for every non-owner, always.
- commandDone in IDLE or OWNED is dropped.

Re-grant timing:
- An IDLE→OWNED re-grant can occur no earlier than the cycle after release. Grant is never held by two requesters, and is never high for a non-requester at grant time.

Reset mid-operation:
- Reset during INFLIGHT clears everything next edge. The writer relies on its own reset.

Error flags:
- timeoutErr and protocolErr clear only on RESET.

Decomposition:
- Package lcd_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_OWNED, ARB_INFLIGHT}
  - localparam LCD_NIBBLE_W = 4
  - the shared LCD command constants (0x80 line-1 address, 0xC0 line-2 address)
- Sub-module rr_pick:
  - Combinational round-robin one-hot selector with inputs req and pointer, output one-hot.
  - Reusable for the keypad/UART arbiters.

Test Plan:
1. Reset, then req=2'b10, reqSend[1] with cmd 4'h8, rs 0 → grant=2'b10 one cycle later. sendCommand pulses 1 cycle with commandToSend=4'h8. commandDone → reqDone=2'b10 in the same cycle.
2. req=2'b11 asserted together after reset → requester 0 granted first. Drop req[0] → requester 1 granted in the following IDLE→OWNED cycle. Re-raise both → requester 0 granted again only after requester 1 releases (pointer wrap).
3. Requester 1 owns, sends 34 nibbles (2 address + 32 char nibbles), while req[0] is held high throughout → grant never switches mid-transaction. All 34 reqDone pulses go to requester 1 only.
4. reqSend[0] while requester 1 owns; second reqSend[1] during INFLIGHT → no extra sendCommand, protocolErr=1, and the in-flight command completes normally.
5. TIMEOUT_W=4, commandDone withheld → after 15 INFLIGHT cycles timeoutErr=1, grant=0, state IDLE. A pending req from the other requester is granted next.
6. RESET asserted during INFLIGHT → next cycle grant=0, sendCommand=0, flags 0. A later commandDone yields no reqDone.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: arbiter state encoding, nibble width and the
// DDRAM address commands used by the text and init sequencers.
package lcd_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_INFLIGHT
    } arb_state_t;

    localparam int LCD_NIBBLE_W = 4;

    localparam logic [7:0] LCD_CMD_LINE1_ADDR = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2_ADDR = 8'hC0;

    // The 4-bit bus carries each byte high nibble first.
    function automatic logic [LCD_NIBBLE_W-1:0] lcd_hi_nibble(input logic [7:0] b);
        return b[7:4];
    endfunction

    function automatic logic [LCD_NIBBLE_W-1:0] lcd_lo_nibble(input logic [7:0] b);
        return b[3:0];
    endfunction

endpackage

// File: rtl/lcd_cmd_arbiter_if.sv
// Requester-side and writer-side signals of the LCD nibble command channel.
interface lcd_cmd_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import lcd_pkg::*;

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              reqSend;
    logic [LCD_NIBBLE_W*NUM_REQ-1:0] reqCmd;
    logic [NUM_REQ-1:0]              reqRs;
    logic [NUM_REQ-1:0]              reqReadBusy;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              reqDone;
    logic [LCD_NIBBLE_W-1:0]         commandToSend;
    logic                            commandToSendRs;
    logic                            read_busy;
    logic                            sendCommand;
    logic                            commandDone;
    logic                            timeoutErr;
    logic                            protocolErr;

    modport slave (
        input  req, reqSend, reqCmd, reqRs, reqReadBusy, commandDone,
        output grant, reqDone, commandToSend, commandToSendRs, read_busy,
               sendCommand, timeoutErr, protocolErr
    );

    modport master (
        output req, reqSend, reqCmd, reqRs, reqReadBusy, commandDone,
        input  grant, reqDone, commandToSend, commandToSendRs, read_busy,
               sendCommand, timeoutErr, protocolErr
    );

endinterface

// File: rtl/lcd_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot of the first active request
// at or after ptr, wrapping modulo N. Zero when nothing is requested.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                gnt[(int'(ptr) + k) % N] = 1'b1;
                found                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Locked-grant arbiter for the shared LCD nibble channel: one owner per
// transaction, one command in flight, watchdog abort of a hung writer.
module lcd_cmd_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int TIMEOUT_W = 20
) (
    input logic              CLK,
    input logic              RESET,
    lcd_cmd_arbiter_if.slave bus
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           owner_q, owner_d;
    logic [LCD_NIBBLE_W-1:0] cmd_q, cmd_d;
    logic                    rs_q, rs_d;
    logic                    rb_q, rb_d;
    logic                    send_q, send_d;
    logic                    terr_q, terr_d;
    logic                    perr_q, perr_d;
    logic [TIMEOUT_W-1:0]    wd_q, wd_d;

    logic [NUM_REQ-1:0]      pick;
    logic [PW-1:0]           pick_idx;
    logic [PW-1:0]           next_ptr;
    logic [TIMEOUT_W-1:0]    wd_inc;
    logic                    illegal_send;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_rr_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    assign next_ptr = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
    assign wd_inc   = wd_q + TIMEOUT_W'(1);

    // A send is only legal from the owner while no command is outstanding.
    assign illegal_send = (|(bus.reqSend & ~grant_q)) ||
                          (state_q == ARB_INFLIGHT && bus.reqSend[owner_q]);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        rs_d    = rs_q;
        rb_d    = rb_q;
        send_d  = 1'b0;
        wd_d    = wd_q;
        terr_d  = terr_q;
        perr_d  = perr_q | illegal_send;

        unique case (state_q)
            ARB_IDLE: begin
                if (|bus.req) begin
                    grant_d = pick;
                    owner_d = pick_idx;
                    state_d = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                // A send in the same cycle as a dropped req defers the release.
                if (bus.reqSend[owner_q]) begin
                    cmd_d   = bus.reqCmd[int'(owner_q)*LCD_NIBBLE_W +: LCD_NIBBLE_W];
                    rs_d    = bus.reqRs[owner_q];
                    rb_d    = bus.reqReadBusy[owner_q];
                    send_d  = 1'b1;
                    wd_d    = '0;
                    state_d = ARB_INFLIGHT;
                end else if (!bus.req[owner_q]) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = ARB_IDLE;
                end
            end
            ARB_INFLIGHT: begin
                wd_d = wd_inc;
                if (bus.commandDone) begin
                    if (bus.req[owner_q]) begin
                        state_d = ARB_OWNED;
                    end else begin
                        grant_d = '0;
                        ptr_d   = next_ptr;
                        state_d = ARB_IDLE;
                    end
                end else if (wd_inc == '1) begin
                    terr_d  = 1'b1;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (RESET) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            cmd_q   <= '0;
            rs_q    <= 1'b0;
            rb_q    <= 1'b0;
            send_q  <= 1'b0;
            wd_q    <= '0;
            terr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            rs_q    <= rs_d;
            rb_q    <= rb_d;
            send_q  <= send_d;
            wd_q    <= wd_d;
            terr_q  <= terr_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.grant           = grant_q;
    assign bus.commandToSend   = cmd_q;
    assign bus.commandToSendRs = rs_q;
    assign bus.read_busy       = rb_q;
    assign bus.sendCommand     = send_q;
    assign bus.timeoutErr      = terr_q;
    assign bus.protocolErr     = perr_q;

    // Completion goes straight back to the owner in the cycle it arrives.
    assign bus.reqDone = (state_q == ARB_INFLIGHT && bus.commandDone) ? grant_q : '0;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Scenario bench for lcd_cmd_arbiter with a transaction-level round-robin model.
module tb_lcd_cmd_arbiter;
    import lcd_pkg::*;

    localparam int NR             = 2;
    localparam int TW             = 4;
    localparam int TIMEOUT_CYCLES = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   rr_ptr = 0;
    int   done_seen [NR];

    lcd_cmd_arbiter_if #(.NUM_REQ(NR)) bus ();

    lcd_cmd_arbiter #(.NUM_REQ(NR), .TIMEOUT_W(TW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "bench time limit");
    end

    function automatic int expected_winner(input logic [NR-1:0] r, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (r[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int who);
        logic [NR-1:0] v;
        v = '0;
        if (who >= 0) v[who] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst               = 1'b1;
        bus.req           = '0;
        bus.reqSend       = '0;
        bus.reqCmd        = '0;
        bus.reqRs         = '0;
        bus.reqReadBusy   = '0;
        bus.commandDone   = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic pulse_send(input int who, input logic [3:0] c, input logic r, input logic b);
        bus.reqSend[who]                               = 1'b1;
        bus.reqCmd[who*LCD_NIBBLE_W +: LCD_NIBBLE_W]   = c;
        bus.reqRs[who]                                 = r;
        bus.reqReadBusy[who]                           = b;
        tick();
        bus.reqSend = '0;
    endtask

    // One legal nibble from the current owner, completed after lat idle cycles.
    task automatic do_nibble(input int who, input logic [3:0] c, input logic r, input logic b,
                             input int lat, input bit drop);
        pulse_send(who, c, r, b);
        total++;
        if (bus.sendCommand !== 1'b1) begin
            bad++; $display("FAIL nib_send: got %b want 1", bus.sendCommand);
        end
        total++;
        if ({bus.commandToSend, bus.commandToSendRs, bus.read_busy} !== {c, r, b}) begin
            bad++; $display("FAIL nib_data: got %h/%b/%b want %h/%b/%b",
                            bus.commandToSend, bus.commandToSendRs, bus.read_busy, c, r, b);
        end
        for (int i = 0; i < lat; i++) begin
            tick();
            total++;
            if ({bus.sendCommand, bus.reqDone} !== {1'b0, {NR{1'b0}}}) begin
                bad++; $display("FAIL nib_wait: send=%b done=%b want 0/0", bus.sendCommand, bus.reqDone);
            end
        end
        bus.commandDone = 1'b1;
        if (drop) bus.req[who] = 1'b0;
        #1;
        total++;
        if (bus.reqDone !== onehot(who)) begin
            bad++; $display("FAIL nib_done: got %b want %b", bus.reqDone, onehot(who));
        end
        if (bus.reqDone[who] === 1'b1) done_seen[who]++;
        tick();
        bus.commandDone = 1'b0;
        if (drop) rr_ptr = (who + 1) % NR;
        total++;
        if ({bus.grant, bus.sendCommand, bus.commandToSend} !== {(drop ? '0 : onehot(who)), 1'b0, c}) begin
            bad++; $display("FAIL nib_after: grant=%b send=%b cmd=%h want %b/0/%h",
                            bus.grant, bus.sendCommand, bus.commandToSend,
                            (drop ? '0 : onehot(who)), c);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (bus.grant !== '0) begin bad++; $display("FAIL rst_grant: got %b want 0", bus.grant); end
        total++;
        if ({bus.sendCommand, bus.commandToSend, bus.commandToSendRs, bus.read_busy} !== 7'b0) begin
            bad++; $display("FAIL rst_writer: send=%b cmd=%h", bus.sendCommand, bus.commandToSend);
        end
        total++;
        if ({bus.timeoutErr, bus.protocolErr, bus.reqDone} !== '0) begin
            bad++; $display("FAIL rst_flags: terr=%b perr=%b done=%b want 0",
                            bus.timeoutErr, bus.protocolErr, bus.reqDone);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        bus.req = 2'b10;
        #1;
        total++;
        if (bus.grant !== 2'b00) begin bad++; $display("FAIL basic_early: got %b want 00", bus.grant); end
        tick();
        total++;
        if (bus.grant !== 2'b10) begin bad++; $display("FAIL basic_grant: got %b want 10", bus.grant); end
        do_nibble(1, 4'h8, 1'b0, 1'b0, 2, 1'b0);
        bus.req = '0;
        tick();
        rr_ptr = 0;
        total++;
        if (bus.grant !== 2'b00) begin bad++; $display("FAIL basic_release: got %b want 00", bus.grant); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.req = 2'b11;
        tick();
        total++;
        if (bus.grant !== onehot(expected_winner(2'b11, rr_ptr))) begin
            bad++; $display("FAIL rr_first: got %b want %b", bus.grant, onehot(expected_winner(2'b11, rr_ptr)));
        end
        bus.req[0] = 1'b0;
        tick();
        rr_ptr = 1;
        total++;
        if (bus.grant !== 2'b00) begin bad++; $display("FAIL rr_rel0: got %b want 00", bus.grant); end
        tick();
        total++;
        if (bus.grant !== onehot(expected_winner(2'b10, rr_ptr))) begin
            bad++; $display("FAIL rr_second: got %b want 10", bus.grant);
        end
        bus.req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.grant !== 2'b10) begin bad++; $display("FAIL rr_locked: got %b want 10", bus.grant); end
        end
        bus.req[1] = 1'b0;
        tick();
        rr_ptr = 0;
        tick();
        total++;
        if (bus.grant !== onehot(expected_winner(2'b01, rr_ptr))) begin
            bad++; $display("FAIL rr_wrap: got %b want 01", bus.grant);
        end
        bus.req = '0;
        tick();
        rr_ptr = 1;
    endtask

    task automatic test_long_txn();
        logic [3:0] nibs [34];
        int         start;
        logic [7:0] ch;
        apply_reset();
        nibs[0] = lcd_hi_nibble(LCD_CMD_LINE1_ADDR);
        nibs[1] = lcd_lo_nibble(LCD_CMD_LINE1_ADDR);
        for (int i = 0; i < 16; i++) begin
            ch = 8'($urandom_range(8'h20, 8'h7E));
            nibs[2 + 2*i]     = lcd_hi_nibble(ch);
            nibs[2 + 2*i + 1] = lcd_lo_nibble(ch);
        end
        bus.req = 2'b10;
        tick();
        bus.req = 2'b11;
        start = done_seen[1];
        for (int i = 0; i < 34; i++) begin
            do_nibble(1, nibs[i], (i >= 2), 1'b0, $urandom_range(0, 4), 1'b0);
        end
        total++;
        if (done_seen[1] - start !== 34) begin
            bad++; $display("FAIL long_done_count: got %0d want 34", done_seen[1] - start);
        end
        bus.req[1] = 1'b0;
        tick();
        rr_ptr = 0;
        tick();
        total++;
        if (bus.grant !== onehot(expected_winner(bus.req, rr_ptr))) begin
            bad++; $display("FAIL long_handover: got %b want 01", bus.grant);
        end
        bus.req = '0;
        tick();
        rr_ptr = 1;
    endtask

    task automatic test_protocol();
        apply_reset();
        bus.req = 2'b10;
        tick();
        pulse_send(0, 4'h3, 1'b1, 1'b1);
        total++;
        if ({bus.sendCommand, bus.commandToSend, bus.protocolErr} !== {1'b0, 4'h0, 1'b1}) begin
            bad++; $display("FAIL proto_nonowner: send=%b cmd=%h perr=%b want 0/0/1",
                            bus.sendCommand, bus.commandToSend, bus.protocolErr);
        end
        apply_reset();
        bus.req = 2'b10;
        tick();
        pulse_send(1, 4'h5, 1'b1, 1'b0);
        total++;
        if ({bus.sendCommand, bus.protocolErr} !== 2'b10) begin
            bad++; $display("FAIL proto_legal: send=%b perr=%b want 1/0", bus.sendCommand, bus.protocolErr);
        end
        pulse_send(1, 4'hA, 1'b0, 1'b1);
        total++;
        if ({bus.sendCommand, bus.commandToSend, bus.protocolErr} !== {1'b0, 4'h5, 1'b1}) begin
            bad++; $display("FAIL proto_inflight: send=%b cmd=%h perr=%b want 0/5/1",
                            bus.sendCommand, bus.commandToSend, bus.protocolErr);
        end
        bus.commandDone = 1'b1;
        #1;
        total++;
        if (bus.reqDone !== 2'b10) begin bad++; $display("FAIL proto_done: got %b want 10", bus.reqDone); end
        tick();
        bus.commandDone = 1'b0;
        do_nibble(1, 4'h6, 1'b1, 1'b1, 1, 1'b1);
        bus.req = '0;
    endtask

    task automatic test_timeout();
        logic exp_terr;
        apply_reset();
        bus.req = 2'b01;
        tick();
        pulse_send(0, 4'h2, 1'b0, 1'b0);
        bus.req = 2'b11;
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            tick();
            exp_terr = (k == TIMEOUT_CYCLES);
            total++;
            if ({bus.timeoutErr, bus.grant} !== {exp_terr, (exp_terr ? 2'b00 : 2'b01)}) begin
                bad++; $display("FAIL to_cycle%0d: terr=%b grant=%b want %b/%b", k,
                                bus.timeoutErr, bus.grant, exp_terr, (exp_terr ? 2'b00 : 2'b01));
            end
        end
        rr_ptr = 1;
        tick();
        total++;
        if (bus.grant !== onehot(expected_winner(2'b11, rr_ptr))) begin
            bad++; $display("FAIL to_regrant: got %b want 10", bus.grant);
        end
        bus.commandDone = 1'b1;
        #1;
        total++;
        if (bus.reqDone !== 2'b00) begin bad++; $display("FAIL to_late_done: got %b want 00", bus.reqDone); end
        tick();
        bus.commandDone = 1'b0;
        total++;
        if (bus.timeoutErr !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", bus.timeoutErr); end
        bus.req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.req = 2'b01;
        tick();
        pulse_send(1, 4'h4, 1'b0, 1'b0);
        pulse_send(0, 4'hF, 1'b1, 1'b1);
        total++;
        if ({bus.sendCommand, bus.protocolErr} !== 2'b11) begin
            bad++; $display("FAIL mid_setup: send=%b perr=%b want 1/1", bus.sendCommand, bus.protocolErr);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({bus.grant, bus.sendCommand, bus.protocolErr, bus.timeoutErr, bus.commandToSend} !== '0) begin
            bad++; $display("FAIL mid_reset: grant=%b send=%b perr=%b terr=%b cmd=%h want all 0",
                            bus.grant, bus.sendCommand, bus.protocolErr, bus.timeoutErr, bus.commandToSend);
        end
        rst     = 1'b0;
        bus.req = '0;
        bus.commandDone = 1'b1;
        #1;
        total++;
        if (bus.reqDone !== 2'b00) begin bad++; $display("FAIL mid_stray_done: got %b want 00", bus.reqDone); end
        tick();
        bus.commandDone = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic test_random();
        logic [NR-1:0] pattern;
        int            win;
        int            n;
        bit            drop;
        apply_reset();
        for (int t = 0; t < 20; t++) begin
            pattern = NR'($urandom_range(1, (1 << NR) - 1));
            bus.req = pattern;
            win     = expected_winner(pattern, rr_ptr);
            tick();
            total++;
            if (bus.grant !== onehot(win)) begin
                bad++; $display("FAIL rnd_grant%0d: got %b want %b", t, bus.grant, onehot(win));
            end
            n    = $urandom_range(1, 4);
            drop = 1'b0;
            for (int j = 0; j < n; j++) begin
                drop = (j == n - 1) && ($urandom_range(0, 1) == 1);
                do_nibble(win, 4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 6), drop);
            end
            if (!drop) begin
                bus.req[win] = 1'b0;
                tick();
                rr_ptr = (win + 1) % NR;
                total++;
                if (bus.grant !== '0) begin
                    bad++; $display("FAIL rnd_release%0d: got %b want 0", t, bus.grant);
                end
            end
            bus.req = '0;
        end
        total++;
        if ({bus.timeoutErr, bus.protocolErr} !== 2'b00) begin
            bad++; $display("FAIL rnd_flags: terr=%b perr=%b want 0/0", bus.timeoutErr, bus.protocolErr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_long_txn();
        test_protocol();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
